// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first. Samples each bit at its centre and holds the last
// good byte with valid/overrun/frame_err status for polling; rd_ack consumes it.
module uart_receiver #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  input  logic       rd_ack,
  output logic [7:0] rdata,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam logic [CW-1:0] CntHalf = CW'(HALF - 1);
  localparam logic [CW-1:0] CntFull = CW'(DIV - 1);

  if (DIV < 4) begin : gen_div_check
    $error("uart_receiver: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= StIdle;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rdata     <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      // Frame-completion updates below take priority over this clear.
      if (rd_ack) begin
        valid     <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (!rx_s) begin
            cnt   <= CntHalf;
            state <= StStart;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            cnt   <= CntFull;
            idx   <= '0;
            state <= StData;
          end
        end
        StData: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            sh  <= {rx_s, sh[7:1]};
            cnt <= CntFull;
            if (idx == 3'd7) begin
              state <= StStop;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        StStop: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Return mid-stop-bit so the next start edge is not missed.
            state <= StIdle;
            busy  <= 1'b0;
            if (rx_s) begin
              rdata <= sh;
              valid <= 1'b1;
              if (valid && !rd_ack) begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: each frame pushes its expected status, and a
// monitor compares it when busy falls at the end of the frame.
module tb_uart_receiver;

  localparam int DIV = 100;

  logic       clk;
  logic       resetn;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] rdata;
  logic       valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ov;
    logic       fe;
    int         lat;
    int         start;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;

  uart_receiver #(
    .CLK_FREQ_HZ(100000000),
    .BAUD_RATE  (1000000)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rxd      (rxd),
    .rd_ack   (rd_ack),
    .rdata    (rdata),
    .valid    (valid),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic v, input logic [7:0] d, input logic ov, input logic fe,
                      input int lat);
    exp_t e;
    e.v = v; e.d = d; e.ov = ov; e.fe = fe; e.lat = lat; e.start = cyc;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; drives a full frame, leaving rxd idle-high afterwards.
  task automatic frame(input logic [7:0] d, input logic stop, input logic ev,
                       input logic [7:0] ed, input logic eov, input logic efe);
    push(ev, ed, eov, efe, 953);
    // A low stop bit looks like a new start edge, which then ends as a glitch.
    if (!stop) push(ev, ed, eov, efe, -1);
    rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      idle(DIV);
    end
    rxd = stop;
    idle(DIV);
    rxd = 1'b1;
  endtask

  task automatic ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic ack_at(input int n);
    idle(n);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  // Monitor: compare on every busy falling edge.
  initial begin
    logic busy_prev;
    exp_t e;
    int   l;
    busy_prev = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (busy_prev && !busy) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_end: got busy fall at cycle %0d expected none", cyc);
        end else begin
          e = q.pop_front();
          check("valid", int'(valid), int'(e.v));
          check("rdata", int'(rdata), int'(e.d));
          check("overrun", int'(overrun), int'(e.ov));
          check("frame_err", int'(frame_err), int'(e.fe));
          if (e.lat >= 0) begin
            l = cyc - e.start;
            checks++;
            if (l < e.lat - 1 || l > e.lat + 1) begin
              failures++;
              $display("FAIL latency: got %0d cycles expected %0d +-1", l, e.lat);
            end
          end
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    int budget;
    resetn = 1'b0;
    rxd    = 1'b1;
    rd_ack = 1'b0;
    idle(3);
    check("rst_rdata", int'(rdata), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    mon_en = 1'b1;
    idle(20);

    // Single byte.
    frame(8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    idle(50);
    ack();
    check("ack_valid", int'(valid), 0);
    idle(200);

    // Back-to-back, acked after the first byte.
    fork
      begin
        frame(8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        frame(8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
      end
      ack_at(960);
    join
    idle(50);
    ack();
    idle(200);

    // Start glitch, then a clean frame.
    push(1'b0, 8'hFF, 1'b0, 1'b0, 53);
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(150);
    frame(8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    idle(50);
    ack();
    idle(200);

    // Framing error.
    frame(8'h55, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    idle(200);
    ack();
    check("fe_cleared", int'(frame_err), 0);
    check("fe_rdata", int'(rdata), 'h3C);
    idle(200);

    // Overrun, then ack coinciding with completion.
    frame(8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    frame(8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
    idle(50);
    ack();
    check("ov_ack_valid", int'(valid), 0);
    check("ov_ack_overrun", int'(overrun), 0);
    idle(200);
    frame(8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    fork
      frame(8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
      ack_at(952);
    join
    idle(50);
    ack();
    idle(200);

    // Reset during bit 4 of 0x99; the sender aborts too.
    push(1'b0, 8'h00, 1'b0, 1'b0, -1);
    rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'h99 >> i) & 8'h01;
      idle(DIV);
    end
    rxd = 1'b1;
    idle(50);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    check("mid_rst_rdata", int'(rdata), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    idle(1000);
    frame(8'h42, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0);

    budget = 5000;
    while (q.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    while (q.size() > 0) begin
      void'(q.pop_front());
      checks++;
      failures++;
      $display("FAIL missing_frame_end: got no busy fall expected one");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Memory-mappable UART receiver, 8N1, LSB first. It is the receive-side counterpart of the SOC's UART transmitter. It samples the asynchronous RXD pin, checks each frame, and holds the last received byte with a valid flag for the processor to poll through the IO page. It also reports overrun, framing error and line-busy status.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz.
BAUD_RATE, 1000000, line rate in bit/s.
DIV (localparam), CLK_FREQ_HZ/BAUD_RATE (integer division), clocks per bit. Must be >= 4. Elaboration fails otherwise.
HALF (localparam), DIV/2, clocks from start-edge detection to start-bit centre.

Ports:
clk  input  1  system clock.
resetn  input  1  synchronous, active-low reset.
rxd  input  1  asynchronous serial input, idle high.
rd_ack  input  1  single-cycle pulse: consume rdata; clears valid, overrun and frame_err.
rdata  output  8  last correctly framed byte.
valid  output  1  rdata holds an unconsumed byte.
overrun  output  1  sticky: a byte was overwritten before being consumed.
frame_err  output  1  sticky: a stop bit sampled low.
busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Synchroniser: rxd passes through a 2-flop chain; both flops reset to 1. All logic below uses the synchronised value rx_s.
- Counter: down-counter cnt, width clog2(DIV). Bit index idx is 3 bits. Shift register sh is 8 bits.
- Reset (resetn=0 at a clk edge): state=IDLE, rdata=0, valid=0, overrun=0, frame_err=0, busy=0, cnt=0, idx=0, sync flops=1.
- Reset mid-frame aborts the frame. No partial byte is ever delivered.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if rx_s==0, load cnt=HALF-1 and go to START. Otherwise stay.
- START: decrement cnt. When cnt==0, sample rx_s.
  - rx_s==1: glitch, return to IDLE with no flags changed.
  - rx_s==0: load cnt=DIV-1, set idx=0, go to DATA.
- DATA: decrement cnt. When cnt==0, shift sh <= {rx_s, sh[7:1]}.
  - idx==7: load cnt=DIV-1, go to STOP.
  - otherwise: idx++ and reload cnt=DIV-1.
- STOP: decrement cnt. When cnt==0, sample rx_s and return to IDLE (mid-stop-bit, so the next start edge is caught).
  - rx_s==1: rdata<=sh, valid<=1, and overrun<=1 if valid==1 and rd_ack==0 that cycle.
  - rx_s==0: frame_err<=1. rdata and valid are unchanged and the byte is discarded.
- rd_ack clears valid, overrun and frame_err on the next edge. rd_ack while valid==0 is harmless.
- Simultaneous rd_ack and byte completion: the new byte wins. valid stays 1, rdata takes the new byte, overrun is not set.
- Simultaneous rd_ack and framing error: frame_err ends 1, valid ends 0.
- Latency:
  - rx_s falls 2 clk edges after rxd falls.
  - Stop-bit sample occurs HALF+9*DIV cycles after the IDLE->START transition.
  - valid is visible the cycle after that edge. With defaults this is about 953 cycles after the rxd falling edge, ±1.
- busy is 1 in START, DATA and STOP; 0 in IDLE.
- Arithmetic is unsigned. cnt never wraps; it is always reloaded at 0.

Test Plan:
- Defaults (DIV=100). Drive frame for 0xA5: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 100 clk. -> valid rises about 953 cycles after the start edge; rdata=0xA5; overrun=0; frame_err=0; busy falls at the same edge valid rises.
- Back-to-back 0x00 then 0xFF, no idle gap, rd_ack pulsed after the first valid. -> rdata=0x00, then 0xFF; overrun=0; frame_err=0.
- Start glitch: rxd low for 20 cycles, then high. -> busy high for about 50 cycles then low; valid=0; no flags set; a following 0x3C frame is received correctly.
- Framing error: frame 0x55 with stop bit driven 0. -> frame_err=1; valid unchanged (0); rdata unchanged. rd_ack -> frame_err=0.
- Overrun: receive 0x11 then 0x22 without rd_ack. -> rdata=0x22, valid=1, overrun=1. rd_ack -> valid=0, overrun=0. Repeat with rd_ack coinciding with the 0x22 completion edge -> valid=1, overrun=0.
- Reset mid-frame: assert resetn=0 for 1 cycle during bit 4 of 0x99. -> all outputs 0; the remaining bits are not delivered; a following clean 0x42 frame gives rdata=0x42.
